// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Consumer side of the response TX FIFO. Pops one byte at a time and sends it on the
//   UART line as 8N1, LSB first. Transmission is gated by a synchronized CTS. When the
//   FIFO stays non-empty, frames follow each other with no idle cycles between them.
//
// Parameters
//   CLK_FREQ_HZ  clk frequency in Hz
//   BAUD_RATE    line rate in bit/s
//
// Ports
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   fifo_data   in   [7:0] FIFO head byte (first-word-fall-through)
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  pop strobe, combinational, one cycle per byte
//   cts_n       in   clear-to-send, active-low, asynchronous
//   uart_tx     out  serial line, registered, idles high
//   tx_busy     out  high while start, data or stop bit is on the line
//   tx_done     out  one-cycle pulse in the last clk of each stop bit
module uart_tx_serializer #(
    parameter int unsigned CLK_FREQ_HZ = 125_000_000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       cts_n,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned DIV   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_serializer: clock/baud ratio must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             uart_tx_q, uart_tx_d;
    logic             cts_meta_q, cts_sync_q;

    logic cts_ok;
    logic last_tick;
    logic load_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            // Synchronizer resets to "not clear to send".
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    always_comb begin
        cts_ok     = ~cts_sync_q;
        last_tick  = (baud_cnt_q == BAUD_LAST);
        load_ok    = ~fifo_empty & cts_ok;

        state_d    = state_q;
        baud_cnt_d = last_tick ? '0 : baud_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;
        tx_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (load_ok) begin
                    fifo_rd_en = 1'b1;
                    shift_d    = fifo_data;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (last_tick) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (last_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (last_tick) begin
                    tx_done = 1'b1;
                    // Reload here so the next start bit follows with no idle gap.
                    if (load_ok) begin
                        fifo_rd_en = 1'b1;
                        shift_d    = fifo_data;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // The line register follows the next state so uart_tx is aligned with state_q.
        unique case (state_d)
            StStart: uart_tx_d = 1'b0;
            StData:  uart_tx_d = shift_d[bit_idx_d];
            default: uart_tx_d = 1'b1;
        endcase

        if (rst) begin
            fifo_rd_en = 1'b0;
            tx_done    = 1'b0;
        end
    end

    assign uart_tx = uart_tx_q;
    assign tx_busy = (state_q != StIdle);

endmodule
